// File: rtl/key_history_display_ctrl.sv
// Two-entry key history driving one shared seven-segment decoder across two digits,
// with a blanking gap between digits. Optional macro: BLANK_UNWRITTEN_EN.
module key_history_display_ctrl #(
  parameter int MUX_DIV     = 48_000,
  parameter int DEAD_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] seg_sel,
  output logic [1:0] digit_en,
  output logic       key_accepted
);

  localparam int CNT_MAX = (MUX_DIV > DEAD_CYCLES) ? MUX_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(MUX_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (DEAD_CYCLES > 0);

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    hist0_q, hist0_d, hist1_q, hist1_d;
  logic [3:0]    seg_sel_q, seg_sel_d;
  logic [1:0]    digit_en_q, digit_en_d;
  logic          key_accepted_q, key_accepted_d;
`ifdef BLANK_UNWRITTEN_EN
  logic          wr0_q, wr0_d, wr1_q, wr1_d;
`endif

  always_comb begin
    hist0_d        = hist0_q;
    hist1_d        = hist1_q;
    key_accepted_d = key_valid;
`ifdef BLANK_UNWRITTEN_EN
    wr0_d = wr0_q;
    wr1_d = wr1_q;
`endif
    if (key_valid) begin
      hist1_d = hist0_q;
      hist0_d = key_code;
`ifdef BLANK_UNWRITTEN_EN
      wr1_d = wr0_q;
      wr0_d = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      SHOW0: if (cnt_q == SHOW_LAST) begin
        cnt_d   = '0;
        state_d = HAS_GAP ? GAP0 : SHOW1;
      end
      GAP0: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = SHOW1;
      end
      SHOW1: if (cnt_q == SHOW_LAST) begin
        cnt_d   = '0;
        state_d = HAS_GAP ? GAP1 : SHOW0;
      end
      GAP1: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = SHOW0;
      end
      default: begin
        cnt_d   = '0;
        state_d = SHOW0;
      end
    endcase
  end

  // Next history values feed the display so a fresh key shows on the very next cycle.
  always_comb begin
    digit_en_d = 2'b00;
    seg_sel_d  = seg_sel_q;
    case (state_q)
      SHOW0: begin
        seg_sel_d = hist0_d;
`ifdef BLANK_UNWRITTEN_EN
        digit_en_d = {1'b0, wr0_d};
`else
        digit_en_d = 2'b01;
`endif
      end
      SHOW1: begin
        seg_sel_d = hist1_d;
`ifdef BLANK_UNWRITTEN_EN
        digit_en_d = {wr1_d, 1'b0};
`else
        digit_en_d = 2'b10;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= SHOW0;
      cnt_q          <= '0;
      hist0_q        <= 4'h0;
      hist1_q        <= 4'h0;
      seg_sel_q      <= 4'h0;
      digit_en_q     <= 2'b00;
      key_accepted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hist0_q        <= hist0_d;
      hist1_q        <= hist1_d;
      seg_sel_q      <= seg_sel_d;
      digit_en_q     <= digit_en_d;
      key_accepted_q <= key_accepted_d;
    end
  end

`ifdef BLANK_UNWRITTEN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr0_q <= 1'b0;
      wr1_q <= 1'b0;
    end else begin
      wr0_q <= wr0_d;
      wr1_q <= wr1_d;
    end
  end
`endif

  assign seg_sel      = seg_sel_q;
  assign digit_en     = digit_en_q;
  assign key_accepted = key_accepted_q;

endmodule

// File: tb/tb_key_history_display_ctrl.sv
// Bench for key_history_display_ctrl: one instance with a blanking gap, one without,
// checked every cycle against a schedule-position model plus hand-computed points.
module tb_key_history_display_ctrl;

  localparam int M = 4;
  localparam int D = 2;
`ifdef BLANK_UNWRITTEN_EN
  localparam bit BLANK = 1'b1;
  localparam logic [1:0] L01 = 2'b00;
  localparam logic [1:0] L10 = 2'b00;
`else
  localparam bit BLANK = 1'b0;
  localparam logic [1:0] L01 = 2'b01;
  localparam logic [1:0] L10 = 2'b10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] seg_a, seg_b;
  logic [1:0] en_a, en_b;
  logic       acc_a, acc_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_history_display_ctrl #(.MUX_DIV(M), .DEAD_CYCLES(D)) dut_gap (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .seg_sel(seg_a), .digit_en(en_a), .key_accepted(acc_a)
  );

  key_history_display_ctrl #(.MUX_DIV(M), .DEAD_CYCLES(0)) dut_nogap (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .seg_sel(seg_b), .digit_en(en_b), .key_accepted(acc_b)
  );

  // Model: history as two slots, schedule as position within the period since reset.
  int         t = 0;
  logic [3:0] h0 = 4'h0, h1 = 4'h0;
  logic       w0 = 1'b0, w1 = 1'b0;
  logic [3:0] exp_seg [2] = '{4'h0, 4'h0};
  logic [1:0] exp_en  [2] = '{2'b00, 2'b00};
  logic       exp_acc = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelStep();
    if (key_valid) begin
      h1 = h0;
      w1 = w0;
      h0 = key_code;
      w0 = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      int dd;
      int pos;
      dd  = (i == 0) ? D : 0;
      pos = t % (2 * M + 2 * dd);
      if (pos < M) begin
        exp_en[i]  = BLANK ? {1'b0, w0} : 2'b01;
        exp_seg[i] = h0;
      end else if (pos < M + dd) begin
        exp_en[i] = 2'b00;
      end else if (pos < 2 * M + dd) begin
        exp_en[i]  = BLANK ? {w1, 1'b0} : 2'b10;
        exp_seg[i] = h1;
      end else begin
        exp_en[i] = 2'b00;
      end
    end
    exp_acc = key_valid;
    t++;
  endtask

  // Inputs change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge clk) begin
    checkOutput("digit_en_gap",  en_a,  reset ? 8'h0 : exp_en[0]);
    checkOutput("seg_sel_gap",   seg_a, reset ? 8'h0 : exp_seg[0]);
    checkOutput("accepted_gap",  acc_a, reset ? 8'h0 : exp_acc);
    checkOutput("digit_en_nogap", en_b,  reset ? 8'h0 : exp_en[1]);
    checkOutput("seg_sel_nogap",  seg_b, reset ? 8'h0 : exp_seg[1]);
    checkOutput("accepted_nogap", acc_b, reset ? 8'h0 : exp_acc);
    checkOutput("onehot_gap",   (en_a == 2'b11), 8'h0);
    checkOutput("onehot_nogap", (en_b == 2'b11), 8'h0);
    if (reset) begin
      t = 0; h0 = 4'h0; h1 = 4'h0; w0 = 1'b0; w1 = 1'b0;
      exp_seg = '{4'h0, 4'h0};
      exp_en  = '{2'b00, 2'b00};
      exp_acc = 1'b0;
    end else begin
      modelStep();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick(1);
    key_valid = 1'b0;
  endtask

  logic [3:0] codes [8] = '{4'hF, 4'h0, 4'hC, 4'h3, 4'hE, 4'h8, 4'h1, 4'hB};

  initial begin
    tick(3);
    reset = 1'b0;
    // No keys: schedule positions 0, 4, 6 after release
    tick(1);
    checkOutput("first_en", en_a, L01);
    checkOutput("first_seg", seg_a, 8'h0);
    checkOutput("first_en_nogap", en_b, L01);
    tick(4);
    checkOutput("gap0_en", en_a, 8'h0);
    checkOutput("nogap_show1_en", en_b, L10);
    tick(2);
    checkOutput("show1_en", en_a, L10);
    checkOutput("show1_seg", seg_a, 8'h0);
    // Keys 5 then A
    applyStimulus(4'h5);
    checkOutput("acc_5", acc_a, 8'h1);
    tick(5);
    checkOutput("show0_5_en", en_a, 8'h1);
    checkOutput("show0_5_seg", seg_a, 8'h5);
    applyStimulus(4'hA);
    checkOutput("show0_A_seg", seg_a, 8'hA);
    checkOutput("acc_A", acc_a, 8'h1);
    tick(6);
    checkOutput("show1_5_en", en_a, 8'h2);
    checkOutput("show1_5_seg", seg_a, 8'h5);
    // Back-to-back keys 3 then 7
    key_valid = 1'b1;
    key_code  = 4'h3;
    tick(1);
    key_code  = 4'h7;
    tick(1);
    key_valid = 1'b0;
    checkOutput("b2b_show1_seg", seg_a, 8'h3);
    checkOutput("b2b_acc", acc_a, 8'h1);
    tick(3);
    checkOutput("b2b_show0_seg", seg_a, 8'h7);
    // Key in the last SHOW0 cycle
    tick(2);
    applyStimulus(4'h9);
    checkOutput("last_show0_seg", seg_a, 8'h9);
    checkOutput("last_show0_en", en_a, 8'h1);
    tick(1);
    checkOutput("gap_after_last_en", en_a, 8'h0);
    checkOutput("gap_hold_seg", seg_a, 8'h9);
    // Reset mid-SHOW1 after keys 1, 2
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    tick(1);
    checkOutput("pre_reset_seg", seg_a, 8'h1);
    reset = 1'b1;
    #1;
    checkOutput("reset_en", en_a, 8'h0);
    checkOutput("reset_seg", seg_a, 8'h0);
    tick(2);
    reset = 1'b0;
    tick(1);
    checkOutput("rerun_en", en_a, L01);
    checkOutput("rerun_seg", seg_a, 8'h0);
    tick(6);
    checkOutput("rerun_show1_en", en_a, L10);
    checkOutput("rerun_show1_seg", seg_a, 8'h0);
    // Free running with keys at assorted schedule positions
    for (int i = 0; i < 8; i++) begin
      applyStimulus(codes[i]);
      tick(i + 3);
    end
    tick(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
